// File: rtl/acq_pkg.sv
// -----------------------------------------------------------------------------
// acq_pkg
// Shared constants and helpers for the acquisition FIFO slice.
//   ACQ_DEF_WIDTH      : default data word width
//   ACQ_DEF_DEPTH_LOG2 : default log2 of storage depth
//   acq_clog2()        : ceil(log2(value)), used to size address/count fields
// -----------------------------------------------------------------------------
package acq_pkg;

  localparam int ACQ_DEF_WIDTH      = 8;
  localparam int ACQ_DEF_DEPTH_LOG2 = 3;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int acq_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/acq_fifo_ram.sv
// -----------------------------------------------------------------------------
// acq_fifo_ram
// WIDTH x DEPTH storage array for acq_fifo. One synchronous write port and one
// asynchronous read port so the FIFO head can fall through without a cycle of
// read latency. Storage is deliberately not reset.
//   clock   : write clock
//   wr_en   : write strobe (already qualified by the FIFO control)
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address (head pointer)
//   rd_data : word at rd_addr, combinational
// -----------------------------------------------------------------------------
module acq_fifo_ram
  import acq_pkg::*;
#(
  parameter int WIDTH  = ACQ_DEF_WIDTH,
  parameter int DEPTH  = 2 ** ACQ_DEF_DEPTH_LOG2,
  parameter int ADDR_W = acq_clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Synchronous write port; contents survive reset and clear.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/acq_fifo.sv
// -----------------------------------------------------------------------------
// acq_fifo
// Synchronous first-word-fall-through FIFO with registered status flags and
// sticky overflow/underflow error bits.
//   clock       : sole clock, rising edge
//   reset       : asynchronous, active-low reset
//   wr_en       : push request, wr_data : push word
//   rd_en       : pop request,  rd_data : head word (meaningful when !empty)
//   clear       : synchronous flush of pointers, count and sticky flags
//   full/empty/almost_full/count : registered occupancy status
//   overflow    : sticky, push attempted while full without a same-cycle pop
//   underflow   : sticky, pop attempted while empty
// -----------------------------------------------------------------------------
module acq_fifo
  import acq_pkg::*;
#(
  parameter int WIDTH       = ACQ_DEF_WIDTH,
  parameter int DEPTH_LOG2  = ACQ_DEF_DEPTH_LOG2,
  parameter int AFULL_LEVEL = (2 ** DEPTH_LOG2) - 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  clear,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH  = 2 ** DEPTH_LOG2;
  localparam int ADDR_W = acq_clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  // With a zero threshold the FIFO is "almost full" even when empty.
  localparam logic             AFULL_RST = (AFULL_LEVEL <= 0) ? 1'b1 : 1'b0;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] count_r;
  logic             full_r;
  logic             empty_r;
  logic             afull_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             pop_ok_s;
  logic             push_ok_s;
  logic             ram_we_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] count_nxt_s;
  logic             full_nxt_s;
  logic             empty_nxt_s;
  logic             afull_nxt_s;
  logic             overflow_nxt_s;
  logic             underflow_nxt_s;

  // Accept decisions, next pointers and next status, all from registered state.
  always_comb begin
    pop_ok_s        = rd_en & ~empty_r;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok_s       = wr_en & (~full_r | pop_ok_s);
    ram_we_s        = push_ok_s & ~clear;
    wr_ptr_nxt_s    = wr_ptr_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    overflow_nxt_s  = overflow_r;
    underflow_nxt_s = underflow_r;

    if (clear) begin
      wr_ptr_nxt_s    = '0;
      rd_ptr_nxt_s    = '0;
      overflow_nxt_s  = 1'b0;
      underflow_nxt_s = 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      overflow_nxt_s  = overflow_r | (wr_en & ~push_ok_s);
      underflow_nxt_s = underflow_r | (rd_en & empty_r);
    end

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    full_nxt_s  = (wr_ptr_nxt_s[PTR_W-1] != rd_ptr_nxt_s[PTR_W-1]) &&
                  (wr_ptr_nxt_s[PTR_W-2:0] == rd_ptr_nxt_s[PTR_W-2:0]);
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    afull_nxt_s = (int'(count_nxt_s) >= AFULL_LEVEL);
  end

  // Control and status registers; every status bit updates on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      afull_r     <= AFULL_RST;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      full_r      <= full_nxt_s;
      empty_r     <= empty_nxt_s;
      afull_r     <= afull_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  acq_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_we_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_r[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  assign full        = full_r;
  assign empty       = empty_r;
  assign almost_full = afull_r;
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule

// File: tb/tb_acq_fifo.sv
// -----------------------------------------------------------------------------
// tb_acq_fifo
// Drives two acq_fifo instances with identical control stimulus: instance A
// with default parameters (8 bits x 8) and instance B with WIDTH=16,
// DEPTH_LOG2=4. A queue-based reference model per instance predicts status;
// popped words are pushed into a scoreboard queue and checked by a separate
// monitor whenever the DUT presents an accepted pop.
// -----------------------------------------------------------------------------
module tb_acq_fifo;

  localparam int DEPTH_A = 8;
  localparam int DEPTH_B = 16;
  localparam int AFL_A   = DEPTH_A - 2;
  localparam int AFL_B   = DEPTH_B - 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;
  logic        clear;

  logic [7:0]  rd_data_a;
  logic        full_a, empty_a, afull_a, ovf_a, udf_a;
  logic [3:0]  count_a;
  logic [15:0] rd_data_b;
  logic        full_b, empty_b, afull_b, ovf_b, udf_b;
  logic [4:0]  count_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: contents as plain queues, sticky flags as bits.
  logic [15:0] mq [2][$];
  logic [15:0] sb [2][$];
  logic        ovf_m [2];
  logic        udf_m [2];
  int          push_cnt [2];

  always #5 clock = ~clock;

  acq_fifo dut_a (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data[7:0]),
    .rd_en       (rd_en),
    .rd_data     (rd_data_a),
    .clear       (clear),
    .full        (full_a),
    .empty       (empty_a),
    .almost_full (afull_a),
    .count       (count_a),
    .overflow    (ovf_a),
    .underflow   (udf_a)
  );

  acq_fifo #(.WIDTH(16), .DEPTH_LOG2(4)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data_b),
    .clear       (clear),
    .full        (full_b),
    .empty       (empty_b),
    .almost_full (afull_b),
    .count       (count_b),
    .overflow    (ovf_b),
    .underflow   (udf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input int depth, input int afl,
                            input logic [4:0] cnt, input logic [4:0] flags);
    int sz;
    logic [4:0] exp_flags;
    sz = mq[i].size();
    exp_flags = {(sz == depth), (sz == 0), (sz >= afl), ovf_m[i], udf_m[i]};
    chk($sformatf("count[%0d]", i), {27'd0, cnt}, sz);
    chk($sformatf("full_empty_afull_ovf_udf[%0d]", i), {27'd0, flags}, {27'd0, exp_flags});
  endtask

  task automatic model_step(input int i, input int depth, input logic rst,
                            input logic wr, input logic [15:0] wd,
                            input logic rd, input logic clr);
    logic pop;
    logic push;
    int   sz;
    if (!rst) begin
      mq[i].delete();
      sb[i].delete();
      ovf_m[i] = 1'b0;
      udf_m[i] = 1'b0;
    end else if (clr) begin
      mq[i].delete();
      ovf_m[i] = 1'b0;
      udf_m[i] = 1'b0;
    end else begin
      sz   = mq[i].size();
      pop  = rd && (sz > 0);
      push = wr && ((sz < depth) || pop);
      if (rd && (sz == 0)) udf_m[i] = 1'b1;
      if (wr && !push)     ovf_m[i] = 1'b1;
      if (pop)  sb[i].push_back(mq[i].pop_front());
      if (push) begin
        mq[i].push_back((i == 0) ? (wd & 16'h00FF) : wd);
        push_cnt[i] = push_cnt[i] + 1;
      end
    end
  endtask

  // One clock of stimulus: check status left by the previous edge, then drive.
  task automatic step(input logic wr, input logic [15:0] wd, input logic rd,
                      input logic clr, input logic rst);
    @(posedge clock);
    #1;
    check_inst(0, DEPTH_A, AFL_A, {1'b0, count_a}, {full_a, empty_a, afull_a, ovf_a, udf_a});
    check_inst(1, DEPTH_B, AFL_B, count_b,          {full_b, empty_b, afull_b, ovf_b, udf_b});
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    clear   = clr;
    reset   = rst;
    model_step(0, DEPTH_A, rst, wr, wd, rd, clr);
    model_step(1, DEPTH_B, rst, wr, wd, rd, clr);
  endtask

  // Monitor: every accepted pop must deliver the oldest predicted word.
  always @(negedge clock) begin
    if (reset && rd_en && !clear) begin
      if (!empty_a) begin
        if (sb[0].size() == 0) chk("pop_a_unexpected", 32'd1, 32'd0);
        else chk("rd_data_a", {24'd0, rd_data_a}, {16'd0, sb[0].pop_front()});
      end
      if (!empty_b) begin
        if (sb[1].size() == 0) chk("pop_b_unexpected", 32'd1, 32'd0);
        else chk("rd_data_b", {16'd0, rd_data_b}, {16'd0, sb[1].pop_front()});
      end
    end
  end

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    rd_en   = 1'b0;
    clear   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ovf_m[i] = 1'b0;
      udf_m[i] = 1'b0;
      push_cnt[i] = 0;
    end
    #2 reset = 1'b0;
    repeat (3) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Fill to full, then overflow attempt, then drain in order.
    for (int k = 1; k <= 8; k++) step(1'b1, 16'(k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h007B, 1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Underflow then clear.
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Simultaneous push/pop while full, then drain.
    for (int k = 1; k <= 8; k++) step(1'b1, 16'(k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b1);
    repeat (8) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Simultaneous push/pop while empty, then pop the new word.
    step(1'b1, 16'h0055, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Clear wins over concurrent push/pop.
    step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h0033, 1'b1, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Random traffic; write-leaning first half, read-leaning second half.
    push_cnt[1] = 0;
    for (int c = 0; c < 200; c++) begin
      step(($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
           16'($urandom_range(0, 65535)),
           ($urandom_range(0, 99) < ((c < 100) ? 80 : 97)) ? 1'b1 : 1'b0,
           1'b0, 1'b1);
    end
    chk("wraps_b_at_least_5", {31'd0, (push_cnt[1] / DEPTH_B) >= 5}, 32'd1);

    // Reset held low for 10 clocks in the middle of traffic.
    repeat (6) step(1'b1, 16'($urandom_range(0, 65535)), 1'b0, 1'b0, 1'b1);
    repeat (10) step($urandom_range(0, 1) == 1, 16'($urandom_range(0, 65535)),
                     $urandom_range(0, 1) == 1, 1'b0, 1'b0);
    repeat (6) step(1'b1, 16'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1,
                    1'b0, 1'b1);
    repeat (10) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    @(negedge clock);
    #1;
    chk("scoreboard_a_drained", sb[0].size(), 32'd0);
    chk("scoreboard_b_drained", sb[1].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acq_fifo.md
ACQ_FIFO -- requirements
Module: acq_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3, log2 of storage depth (DEPTH = 2**DEPTH_LOG2 words, all usable).
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  push request.
REQ-007 SHALL have port wr_data  input  WIDTH  push data.
REQ-008 SHALL have port rd_en  input  1  pop request.
REQ-009 SHALL have port rd_data  output  WIDTH  head word, first-word-fall-through (valid whenever empty=0).
REQ-010 SHALL have port clear  input  1  synchronous flush of contents and sticky flags.
REQ-011 SHALL have port full  output  1  occupancy == DEPTH.
REQ-012 SHALL have port empty  output  1  occupancy == 0.
REQ-013 SHALL have port almost_full  output  1  occupancy >= AFULL_LEVEL.
REQ-014 SHALL have port count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow  output  1  sticky: push attempted while full.
REQ-016 SHALL have port underflow  output  1  sticky: pop attempted while empty.

Function
REQ-017 SHALL accept a push when wr_en=1 and (full=0 or an accepted pop occurs the same cycle); word stored, write pointer advances.
REQ-018 SHALL accept a pop when rd_en=1 and empty=0; read pointer advances, next head appears on rd_data the following cycle.
REQ-019 SHALL, on simultaneous accepted push and pop, leave count unchanged; when full, the push is accepted because the pop frees the slot.
REQ-020 SHALL, on simultaneous wr_en and rd_en while empty, accept the push only, set underflow; new word visible on rd_data next cycle.
REQ-021 SHALL, on wr_en while full without accepted pop, drop the word, leave contents/count unchanged, set overflow.
REQ-022 SHALL, on rd_en while empty, leave state unchanged and set underflow.
REQ-023 SHALL wrap pointers modulo DEPTH; pointers DEPTH_LOG2+1 bits, full/empty derived from MSB-differing/equal comparison.
REQ-024 SHALL keep count, full, empty, almost_full registered and consistent with each other every cycle; zero-latency update on the clock edge of the accepted operation.
REQ-025 SHALL, when clear=1, set pointers/count to 0 and clear overflow/underflow, ignoring wr_en/rd_en that cycle; storage contents unchanged.
REQ-026 SHALL hold overflow/underflow at 1 until clear or reset.
REQ-027 SHALL present rd_data as don't-care while empty; bench must not check it.

Reset
REQ-028 SHALL, on reset low, immediately set count=0, empty=1, full=0, almost_full=0 (when AFULL_LEVEL>0), overflow=0, underflow=0, pointers 0.
REQ-029 SHALL discard any in-progress push/pop when reset asserts mid-operation; storage RAM not reset.
REQ-030 SHALL resume normal operation on the first rising clock edge after reset deasserts.

Structure
REQ-031 SHALL place DEPTH-derived width helper (clog2 function) and default constants in shared package acq_pkg.
REQ-032 SHALL instantiate one sub-module acq_fifo_ram (WIDTH x DEPTH, one synchronous write port, one asynchronous read port); control logic stays in acq_fifo.

Verification
REQ-033 Reset: hold reset low 10 clocks mid-traffic -> count=0, empty=1, overflow=0, underflow=0 within the reset period.
REQ-034 Fill/drain (defaults): push 0x01..0x08 -> full=1, count=8, almost_full asserted at count=6; pop 8 -> data 0x01..0x08 in order, empty=1.
REQ-035 Overflow: full, push 0x7B -> overflow=1, count=8, subsequent pops return 0x01..0x08 (0x7B absent).
REQ-036 Underflow: empty, rd_en 1 cycle -> underflow=1, count=0; clear 1 cycle -> underflow=0.
REQ-037 Simultaneous: full, wr_en+rd_en with 0xAA -> count stays 8, pop sequence ends with 0xAA; empty, wr_en+rd_en with 0x55 -> count=1, rd_data=0x55, underflow=1.
REQ-038 Wrap: WIDTH=16, DEPTH_LOG2=4, 100 random push/pop cycles vs reference queue model -> zero data/count mismatches, pointers wrap at least 5 times.
